rat_flow_ctrl: RTL and testbench

RAT_FLOW_CTRL -- requirements
Module: rat_flow_ctrl

---
 rtl/rat_pkg.sv | 37 +++
 rtl/rat_flow_ctrl.sv | 141 ++++++++++++++
 tb/tb_rat_flow_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rat_pkg.sv
// Shared definitions for the RAT control slice.
// Holds the flow-control FSM state encoding, the 7-bit opcode constants
// decoded by rat_flow_ctrl, and the select codes for the program-counter
// source mux and the scratch RAM address mux.
package rat_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  // Opcodes as {instr[17:13], instr[1:0]}
  localparam logic [6:0] OP_BRN   = 7'b0010000;
  localparam logic [6:0] OP_CALL  = 7'b0010001;
  localparam logic [6:0] OP_BREQ  = 7'b0010010;
  localparam logic [6:0] OP_BRNE  = 7'b0010011;
  localparam logic [6:0] OP_BRCS  = 7'b0010100;
  localparam logic [6:0] OP_BRCC  = 7'b0010101;
  localparam logic [6:0] OP_RET   = 7'b0110010;
  localparam logic [6:0] OP_SEI   = 7'b0110100;
  localparam logic [6:0] OP_CLI   = 7'b0110101;
  localparam logic [6:0] OP_RETID = 7'b0110110;
  localparam logic [6:0] OP_RETIE = 7'b0110111;

  // Program-counter source select
  localparam logic [1:0] PC_SEL_IMM   = 2'd0;
  localparam logic [1:0] PC_SEL_STACK = 2'd1;
  localparam logic [1:0] PC_SEL_ISR   = 2'd2;
  localparam logic [1:0] PC_SEL_ZERO  = 2'd3;

  // Scratch RAM address select
  localparam logic [1:0] SCR_ADDR_SP    = 2'd2;
  localparam logic [1:0] SCR_ADDR_SP_M1 = 2'd3;

endpackage

// File: rtl/rat_flow_ctrl.sv
// Program-flow control unit for the RAT CPU.
// Sequences INIT -> FETCH -> EXEC (-> INTR) and drives the program counter,
// stack pointer, scratch RAM and shadow-flag controls for branches,
// CALL/RET, interrupt enable/disable and interrupt entry.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   OPCODE_HI_5/OPCODE_LO_2  instruction bits [17:13] / [1:0], valid in EXEC
//   C_FLAG, Z_FLAG           carry / zero flags for conditional branches
//   INT                      level interrupt request
//   PC_*                     program counter reset / load / increment / source
//   SP_*                     stack pointer reset / increment / decrement
//   SCR_*                    scratch RAM write enable, address and data select
//   FLG_SHAD_LD, FLG_LD_SEL  save flags to shadow / restore flags from shadow
//   I_EN                     registered interrupt enable
module rat_flow_ctrl
  import rat_pkg::*;
#(
  parameter logic [1:0] ISR_SEL = 2'd2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] OPCODE_HI_5,
  input  logic [1:0] OPCODE_LO_2,
  input  logic       C_FLAG,
  input  logic       Z_FLAG,
  input  logic       INT,
  output logic       PC_RST,
  output logic       PC_LD,
  output logic       PC_INC,
  output logic [1:0] PC_MUX_SEL,
  output logic       SP_RST,
  output logic       SP_INCR,
  output logic       SP_DECR,
  output logic       SCR_WE,
  output logic [1:0] SCR_ADDR_SEL,
  output logic       SCR_DATA_SEL,
  output logic       FLG_SHAD_LD,
  output logic       FLG_LD_SEL,
  output logic       I_EN
);

  state_t     state_q;
  state_t     state_next;
  logic       i_en_q;
  logic       i_en_next;
  logic [6:0] opcode;

  assign opcode = {OPCODE_HI_5, OPCODE_LO_2};
  assign I_EN   = i_en_q;

  // i_en_next is resolved before the transition so that SEI/RETIE can
  // vector immediately and CLI/RETID suppress an interrupt in the same EXEC.
  always_comb begin
    PC_RST       = 1'b0;
    PC_LD        = 1'b0;
    PC_INC       = 1'b0;
    PC_MUX_SEL   = PC_SEL_IMM;
    SP_RST       = 1'b0;
    SP_INCR      = 1'b0;
    SP_DECR      = 1'b0;
    SCR_WE       = 1'b0;
    SCR_ADDR_SEL = '0;
    SCR_DATA_SEL = 1'b0;
    FLG_SHAD_LD  = 1'b0;
    FLG_LD_SEL   = 1'b0;
    i_en_next    = i_en_q;
    state_next   = state_q;

    case (state_q)
      ST_INIT: begin
        PC_RST     = 1'b1;
        SP_RST     = 1'b1;
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        PC_INC     = 1'b1;
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        case (opcode)
          OP_BRN: begin
            PC_LD      = 1'b1;
            PC_MUX_SEL = PC_SEL_IMM;
          end
          OP_BREQ: PC_LD = Z_FLAG;
          OP_BRNE: PC_LD = ~Z_FLAG;
          OP_BRCS: PC_LD = C_FLAG;
          OP_BRCC: PC_LD = ~C_FLAG;
          OP_CALL: begin
            PC_LD        = 1'b1;
            PC_MUX_SEL   = PC_SEL_IMM;
            SP_DECR      = 1'b1;
            SCR_WE       = 1'b1;
            SCR_ADDR_SEL = SCR_ADDR_SP_M1;
            SCR_DATA_SEL = 1'b1;
          end
          OP_RET, OP_RETID, OP_RETIE: begin
            PC_LD        = 1'b1;
            PC_MUX_SEL   = PC_SEL_STACK;
            SP_INCR      = 1'b1;
            SCR_ADDR_SEL = SCR_ADDR_SP;
            FLG_LD_SEL   = (opcode != OP_RET);
            if (opcode == OP_RETID) i_en_next = 1'b0;
            if (opcode == OP_RETIE) i_en_next = 1'b1;
          end
          OP_SEI: i_en_next = 1'b1;
          OP_CLI: i_en_next = 1'b0;
          default: ;
        endcase
        state_next = (INT && i_en_next) ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        PC_LD        = 1'b1;
        PC_MUX_SEL   = ISR_SEL;
        SP_DECR      = 1'b1;
        SCR_WE       = 1'b1;
        SCR_ADDR_SEL = SCR_ADDR_SP_M1;
        SCR_DATA_SEL = 1'b1;
        FLG_SHAD_LD  = 1'b1;
        i_en_next    = 1'b0;
        state_next   = ST_FETCH;
      end

      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      i_en_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      i_en_q  <= i_en_next;
    end
  end

endmodule

// File: tb/tb_rat_flow_ctrl.sv
// Scoreboard testbench for rat_flow_ctrl.
// The driver applies one cycle of inputs per step and queues the
// hand-computed output vector for that cycle; the monitor pops and compares
// on every falling edge while entries are pending.
// Vector layout: {PC_RST, PC_LD, PC_INC, PC_MUX_SEL[1:0], SP_RST, SP_INCR,
//   SP_DECR, SCR_WE, SCR_ADDR_SEL[1:0], SCR_DATA_SEL, FLG_SHAD_LD,
//   FLG_LD_SEL, I_EN, 1'b0}
module tb_rat_flow_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] OPCODE_HI_5;
  logic [1:0] OPCODE_LO_2;
  logic       C_FLAG;
  logic       Z_FLAG;
  logic       INT;
  logic       PC_RST, PC_LD, PC_INC, SP_RST, SP_INCR, SP_DECR, SCR_WE;
  logic       SCR_DATA_SEL, FLG_SHAD_LD, FLG_LD_SEL, I_EN;
  logic [1:0] PC_MUX_SEL, SCR_ADDR_SEL;

  rat_flow_ctrl #(.ISR_SEL(2'd2)) dut (
    .CLK(CLK), .RST(RST), .OPCODE_HI_5(OPCODE_HI_5), .OPCODE_LO_2(OPCODE_LO_2),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .INT(INT),
    .PC_RST(PC_RST), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL),
    .SP_RST(SP_RST), .SP_INCR(SP_INCR), .SP_DECR(SP_DECR),
    .SCR_WE(SCR_WE), .SCR_ADDR_SEL(SCR_ADDR_SEL), .SCR_DATA_SEL(SCR_DATA_SEL),
    .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_LD_SEL(FLG_LD_SEL), .I_EN(I_EN)
  );

  always #5 CLK = ~CLK;

  localparam logic [15:0] V_INIT  = 16'h8400;
  localparam logic [15:0] V_FETCH = 16'h2000;
  localparam logic [15:0] V_NONE  = 16'h0000;
  localparam logic [15:0] V_BR    = 16'h4000;
  localparam logic [15:0] V_CALL  = 16'h41F0;
  localparam logic [15:0] V_RET   = 16'h4A40;
  localparam logic [15:0] V_RETI  = 16'h4A44;
  localparam logic [15:0] V_INTR  = 16'h51F8;
  localparam logic [15:0] V_IEN   = 16'h0002;

  localparam logic [6:0] NOP   = 7'b0000000;
  localparam logic [6:0] BRN   = 7'b0010000;
  localparam logic [6:0] CALL  = 7'b0010001;
  localparam logic [6:0] BREQ  = 7'b0010010;
  localparam logic [6:0] BRNE  = 7'b0010011;
  localparam logic [6:0] BRCS  = 7'b0010100;
  localparam logic [6:0] BRCC  = 7'b0010101;
  localparam logic [6:0] RET   = 7'b0110010;
  localparam logic [6:0] SEI   = 7'b0110100;
  localparam logic [6:0] CLI   = 7'b0110101;
  localparam logic [6:0] RETID = 7'b0110110;
  localparam logic [6:0] RETIE = 7'b0110111;
  localparam logic [6:0] OTHER = 7'b1000011;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        total = 0;
  int        bad   = 0;

  wire [15:0] act = {PC_RST, PC_LD, PC_INC, PC_MUX_SEL, SP_RST, SP_INCR,
                     SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL,
                     FLG_SHAD_LD, FLG_LD_SEL, I_EN, 1'b0};

  // Monitor
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      e = sb.pop_front();
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic [6:0] op,
                      input logic c, input logic z, input logic irq,
                      input logic [15:0] ex);
    sb_entry_t e;
    @(posedge CLK);
    #1;
    RST         = rst;
    OPCODE_HI_5 = op[6:2];
    OPCODE_LO_2 = op[1:0];
    C_FLAG      = c;
    Z_FLAG      = z;
    INT         = irq;
    e.name = nm;
    e.exp  = ex;
    sb.push_back(e);
  endtask

  // One FETCH cycle followed by one EXEC cycle; ien is I_EN during both.
  task automatic instr(input string nm, input logic [6:0] op, input logic c,
                       input logic z, input logic irq, input logic ien,
                       input logic [15:0] ex);
    logic [15:0] iv;
    iv = ien ? V_IEN : V_NONE;
    step({nm, "_fetch"}, 1'b0, NOP, 1'b0, 1'b0, irq, V_FETCH | iv);
    step({nm, "_exec"},  1'b0, op,  c,    z,    irq, ex | iv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; OPCODE_HI_5 = '0; OPCODE_LO_2 = '0;
    C_FLAG = 1'b0; Z_FLAG = 1'b0; INT = 1'b0;

    // Reset held, then released; one trailing INIT cycle
    step("rst_a", 1'b1, NOP, 1'b0, 1'b0, 1'b0, V_INIT);
    step("rst_b", 1'b1, NOP, 1'b0, 1'b0, 1'b0, V_INIT);
    step("rst_c", 1'b1, NOP, 1'b0, 1'b0, 1'b0, V_INIT);
    step("rst_rel", 1'b0, NOP, 1'b0, 1'b0, 1'b0, V_INIT);
    instr("nop0",  NOP,   1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("other", OTHER, 1'b1, 1'b1, 1'b0, 1'b0, V_NONE);

    // Branches
    instr("breq_t", BREQ, 1'b0, 1'b1, 1'b0, 1'b0, V_BR);
    instr("breq_n", BREQ, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("brne_t", BRNE, 1'b0, 1'b0, 1'b0, 1'b0, V_BR);
    instr("brne_n", BRNE, 1'b0, 1'b1, 1'b0, 1'b0, V_NONE);
    instr("brcs_t", BRCS, 1'b1, 1'b0, 1'b0, 1'b0, V_BR);
    instr("brcs_n", BRCS, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("brcc_t", BRCC, 1'b0, 1'b1, 1'b0, 1'b0, V_BR);
    instr("brcc_n", BRCC, 1'b1, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("brn",    BRN,  1'b0, 1'b0, 1'b0, 1'b0, V_BR);

    // CALL then RET
    instr("call", CALL, 1'b0, 1'b0, 1'b0, 1'b0, V_CALL);
    instr("ret",  RET,  1'b0, 1'b0, 1'b0, 1'b0, V_RET);

    // INT with interrupts disabled is ignored
    instr("nop_int_dis", NOP, 1'b0, 1'b0, 1'b1, 1'b0, V_NONE);

    // SEI, then interrupt on a no-op; INT held through ISR entry does not nest
    instr("sei1", SEI, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("nop_int", NOP, 1'b0, 1'b0, 1'b1, 1'b1, V_NONE);
    step("intr1", 1'b0, NOP, 1'b0, 1'b0, 1'b1, V_INTR | V_IEN);
    instr("no_nest", NOP, 1'b0, 1'b0, 1'b1, 1'b0, V_NONE);

    // CLI with INT high does not vector
    instr("sei2", SEI, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("cli_int", CLI, 1'b0, 1'b0, 1'b1, 1'b1, V_NONE);
    instr("after_cli", NOP, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);

    // RETIE with INT high and I_EN low vectors immediately
    instr("retie_int", RETIE, 1'b0, 1'b0, 1'b1, 1'b0, V_RETI);
    step("intr2", 1'b0, NOP, 1'b0, 1'b0, 1'b0, V_INTR | V_IEN);
    instr("after_intr2", NOP, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);

    // SEI with INT high vectors immediately
    instr("sei_int", SEI, 1'b0, 1'b0, 1'b1, 1'b0, V_NONE);
    step("intr3", 1'b0, NOP, 1'b0, 1'b0, 1'b0, V_INTR | V_IEN);

    // RETID with INT high clears I_EN and does not vector
    instr("sei3", SEI, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("retid_int", RETID, 1'b0, 1'b0, 1'b1, 1'b1, V_RETI);
    instr("after_retid", NOP, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);

    // Reset asserted during ST_INTR
    instr("sei4", SEI, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    instr("nop_int2", NOP, 1'b0, 1'b0, 1'b1, 1'b1, V_NONE);
    step("intr_rst", 1'b1, NOP, 1'b0, 1'b0, 1'b0, V_INTR | V_IEN);
    step("post_rst", 1'b0, NOP, 1'b0, 1'b0, 1'b0, V_INIT);
    instr("post_rst_nop", NOP, 1'b0, 1'b0, 1'b1, 1'b0, V_NONE);

    // Reset asserted mid-CALL
    instr("call_rst_pre", NOP, 1'b0, 1'b0, 1'b0, 1'b0, V_NONE);
    step("call_fetch", 1'b0, NOP, 1'b0, 1'b0, 1'b0, V_FETCH);
    step("call_rst", 1'b1, CALL, 1'b0, 1'b0, 1'b0, V_CALL);
    step("call_rst_init", 1'b0, NOP, 1'b0, 1'b0, 1'b0, V_INIT);
    step("call_rst_fetch", 1'b0, NOP, 1'b0, 1'b0, 1'b0, V_FETCH);

    begin
      int unsigned wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 20) begin
        @(posedge CLK);
        wait_cycles++;
      end
      @(posedge CLK);
      if (sb.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
